map_loader: RTL and testbench

MAP_LOADER -- requirements
Module: map_loader

---
 rtl/map_loader_pkg.sv | 7 +
 rtl/map_loader_ram.sv | 17 +
 rtl/map_loader.sv | 67 ++++++
 tb/tb_map_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/map_loader_pkg.sv
// map_loader_pkg: FSM state encodings and default map dimensions shared by the map loader files
package map_loader_pkg;
  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD, S_DONE} state_t;
  localparam int DEF_COLBITS = 4;
  localparam int DEF_ROWBITS = 4;
  localparam int DEF_BITS    = 2;
endpackage

// File: rtl/map_loader_ram.sv
// map_ram: map storage; ports clk, i_we/i_waddr/i_wdata sync write, i_raddr -> o_rdata combinational read
module map_ram #(
  parameter int AW   = 8,
  parameter int BITS = 2
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [BITS-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr,
  output logic [BITS-1:0] o_rdata
);
  logic [BITS-1:0] r_mem [2**AW];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/map_loader.sv
// map_loader: clears map to a border pattern, streams full-map loads (load_start/abort, in_valid/ready/data), IDLE pokes (wr_*), busy/done status, combinational read (rd_* -> rd_val)
module map_loader import map_loader_pkg::*; #(
  parameter int COLBITS = DEF_COLBITS,
  parameter int ROWBITS = DEF_ROWBITS,
  parameter int BITS    = DEF_BITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_start,
  input  logic               load_abort,
  input  logic               in_valid,
  input  logic [BITS-1:0]    in_data,
  output logic               in_ready,
  input  logic               wr_en,
  input  logic [ROWBITS-1:0] wr_row,
  input  logic [COLBITS-1:0] wr_col,
  input  logic [BITS-1:0]    wr_val,
  output logic               busy,
  output logic               done,
  input  logic [ROWBITS-1:0] rd_row,
  input  logic [COLBITS-1:0] rd_col,
  output logic [BITS-1:0]    rd_val
);
  localparam int AW = ROWBITS + COLBITS;
  state_t r_state, w_next;
  logic [AW-1:0] r_cnt, w_waddr;
  logic [BITS-1:0] w_wdata;
  logic w_last, w_acc, w_border, w_we;
  assign w_last = &r_cnt;
  assign w_acc = r_state == S_LOAD && in_valid && !load_abort;
  assign w_border = r_cnt[AW-1:COLBITS] == '0 || &r_cnt[AW-1:COLBITS] ||
                    r_cnt[COLBITS-1:0] == '0 || &r_cnt[COLBITS-1:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == S_IDLE && load_start) ? '0 :
                 (r_state == S_CLEAR || w_acc) ? r_cnt + 1'b1 : r_cnt;
    end
  always_comb begin
    w_next   = S_IDLE;
    w_we     = 1'b0;
    w_waddr  = r_cnt;
    w_wdata  = in_data;
    in_ready = r_state == S_LOAD;
    busy     = r_state == S_CLEAR || r_state == S_LOAD;
    done     = r_state == S_DONE;
    w_next   = r_state == S_CLEAR ? (w_last ? S_DONE : S_CLEAR) :
               r_state == S_IDLE  ? (load_start ? S_LOAD : S_IDLE) :
               r_state == S_LOAD  ? (load_abort ? S_IDLE : (w_acc && w_last) ? S_DONE : S_LOAD) :
               S_IDLE;
    w_we     = r_state == S_CLEAR || w_acc || (r_state == S_IDLE && wr_en && !load_start);
    w_waddr  = r_state == S_IDLE ? {wr_row, wr_col} : r_cnt;
    w_wdata  = r_state == S_CLEAR ? (w_border ? '1 : '0) :
               r_state == S_LOAD ? in_data : wr_val;
  end
  map_ram #(.AW(AW), .BITS(BITS)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr ({rd_row, rd_col}),
    .o_rdata (rd_val)
  );
endmodule

// File: tb/tb_map_loader.sv
// tb_map_loader: scoreboard bench for map_loader clear, load, stall, abort, poke and reset behaviour
module tb_map_loader;
  logic clk = 1'b0, reset = 1'b1, load_start = 1'b0, load_abort = 1'b0, in_valid = 1'b0, wr_en = 1'b0;
  logic in_ready, busy, done;
  logic [1:0] in_data = '0, wr_val = '0, rd_val;
  logic [3:0] wr_row = '0, wr_col = '0, rd_row = '0, rd_col = '0;
  typedef struct packed {logic [3:0] r; logic [3:0] c; logic [1:0] v;} exp_t;
  exp_t sb[$];
  logic [1:0] model [256];
  logic [7:0] wa = '0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  map_loader dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_abort(load_abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_val(wr_val),
    .busy(busy), .done(done), .rd_row(rd_row), .rd_col(rd_col), .rd_val(rd_val)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_model;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = i[7:0];
      model[a] = (a[7:4] == 0 || a[7:4] == 15 || a[3:0] == 0 || a[3:0] == 15) ? 2'd3 : 2'd0;
    end
  endtask
  task automatic push_exp(input logic [3:0] r, input logic [3:0] c, input logic [1:0] v);
    sb.push_back(exp_t'({r, c, v}));
  endtask
  task automatic push_map;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = i[7:0];
      push_exp(a[7:4], a[3:0], model[a]);
    end
  endtask
  task automatic drain(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_row = e.r;
      rd_col = e.c;
      #1;
      checks++;
      if (rd_val !== e.v) begin
        errors++;
        $display("FAIL %s rd(%0d,%0d) got %0d want %0d", tag, e.r, e.c, rd_val, e.v);
      end
    end
    tick();
  endtask
  task automatic run_clear(input string tag);
    int bc, dc, de;
    bc = int'(busy);
    dc = 0;
    de = 0;
    for (int k = 1; k < 300; k++) begin
      tick();
      bc += int'(busy);
      if (done) begin
        dc++;
        de = k;
      end
    end
    checks++;
    if (bc != 256) begin errors++; $display("FAIL %s busy_cycles got %0d want 256", tag, bc); end
    checks++;
    if (dc != 1 || de != 256) begin errors++; $display("FAIL %s done_pulse got count %0d edge %0d want 1 at 256", tag, dc, de); end
    checks++;
    if ({busy, done, in_ready} !== 3'b000) begin errors++; $display("FAIL %s idle_status got %b want 000", tag, {busy, done, in_ready}); end
  endtask
  task automatic start_load(input bit hold, input string tag);
    load_start = 1'b1;
    tick();
    load_start = hold;
    wa = '0;
    checks++;
    if ({busy, in_ready, done} !== 3'b110) begin errors++; $display("FAIL %s enter_load got %b want 110", tag, {busy, in_ready, done}); end
  endtask
  task automatic stream(input int n, input bit fixed, input logic [1:0] fv, input bit toggle,
                        output int acc, output int edges, output int dn, output int de);
    logic v, rdy;
    logic [1:0] d;
    acc = 0; edges = 0; dn = 0; de = 0;
    while (acc < n && edges < 2000) begin
      v = toggle ? edges[0] : 1'b1;
      d = fixed ? fv : (wa[5:4] ^ wa[1:0]);
      in_valid = v;
      in_data = d;
      rdy = in_ready;
      tick();
      edges++;
      if (v && rdy) begin
        model[wa] = d;
        wa++;
        acc++;
      end
      if (done) begin
        dn++;
        de = edges;
      end
    end
    in_valid = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy, done, in_ready} !== 3'b100) begin errors++; $display("FAIL reset_status got %b want 100", {busy, done, in_ready}); end
    reset = 1'b0;
    run_clear("clear");
    clear_model();
    push_exp(0, 5, 3); push_exp(7, 7, 0); push_exp(15, 15, 3); push_exp(8, 0, 3);
    drain("clear_spec");
    push_map();
    drain("clear_map");
  endtask
  task automatic test_abort;
    int acc, edges, dn, de;
    start_load(1'b0, "abort");
    stream(20, 1'b1, 2'd1, 1'b0, acc, edges, dn, de);
    checks++;
    if (acc != 20 || dn != 0) begin errors++; $display("FAIL abort_stream got acc %0d done %0d want 20 0", acc, dn); end
    in_valid = 1'b1;
    in_data = 2'd1;
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({busy, done, in_ready} !== 3'b000) begin errors++; $display("FAIL abort_status got %b want 000", {busy, done, in_ready}); end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b want 0", done); end
    push_exp(1, 3, 1); push_exp(1, 4, 0);
    drain("abort_spec");
    push_map();
    drain("abort_map");
  endtask
  task automatic test_poke;
    wr_en = 1'b1; wr_row = 4'd2; wr_col = 4'd9; wr_val = 2'd1; load_abort = 1'b1;
    tick();
    wr_en = 1'b0; load_abort = 1'b0;
    model[8'h29] = 2'd1;
    checks++;
    if ({busy, in_ready} !== 2'b00) begin errors++; $display("FAIL poke_stay_idle got %b want 00", {busy, in_ready}); end
    push_exp(2, 9, 1);
    drain("poke_idle");
    start_load(1'b0, "poke_load");
    wr_en = 1'b1; wr_val = 2'd2;
    tick();
    wr_en = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL poke_in_load got %b want 1", in_ready); end
    push_exp(2, 9, 1);
    drain("poke_load_ignored");
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL poke_abort got %b want 0", in_ready); end
    wr_en = 1'b1; wr_val = 2'd3; load_start = 1'b1;
    tick();
    wr_en = 1'b0; load_start = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL poke_start_load got %b want 1", in_ready); end
    push_exp(2, 9, 1);
    drain("poke_dropped");
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
  endtask
  task automatic test_load(input bit toggle, input string tag);
    int acc, edges, dn, de;
    start_load(toggle, tag);
    stream(256, 1'b0, 2'd0, toggle, acc, edges, dn, de);
    load_start = 1'b0;
    checks++;
    if (acc != 256) begin errors++; $display("FAIL %s accepts got %0d want 256", tag, acc); end
    checks++;
    if (edges != (toggle ? 512 : 256)) begin errors++; $display("FAIL %s cycles got %0d want %0d", tag, edges, toggle ? 512 : 256); end
    checks++;
    if (dn != 1 || de != edges) begin errors++; $display("FAIL %s done got count %0d edge %0d want 1 at %0d", tag, dn, de, edges); end
    tick();
    checks++;
    if ({busy, done, in_ready} !== 3'b000) begin errors++; $display("FAIL %s after_done got %b want 000", tag, {busy, done, in_ready}); end
    push_exp(3, 1, 2); push_exp(15, 14, 1);
    drain({tag, "_spec"});
    push_map();
    drain({tag, "_map"});
  endtask
  task automatic test_reset_mid_load;
    int acc, edges, dn, de;
    start_load(1'b0, "rst_mid");
    stream(100, 1'b0, 2'd0, 1'b0, acc, edges, dn, de);
    checks++;
    if (acc != 100 || dn != 0) begin errors++; $display("FAIL rst_mid_stream got acc %0d done %0d want 100 0", acc, dn); end
    in_valid = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, in_ready} !== 3'b100) begin errors++; $display("FAIL rst_mid_async got %b want 100", {busy, done, in_ready}); end
    in_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    run_clear("rst_mid_clear");
    clear_model();
    push_map();
    drain("rst_mid_map");
  endtask
  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_abort();
    test_poke();
    test_load(1'b0, "load");
    test_reset_mid_load();
    test_load(1'b1, "load_toggle");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
